pipe_reg: RTL and testbench

Parametrised, elastic pipeline register: a chain of DEPTH stages, each WIDTH bits wide, with a valid/ready handshake on both sides, synchronous flush and an occupancy count. Replaces fixed-width banks of single-bit flip-flops between datapath stages. Each stage holds its data under back-pressure. Flush discards all in-flight data, for example on a branch redirect.

---
 rtl/pipe_reg.sv | 93 +++++++++
 tb/tb_pipe_reg.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready pipeline of DEPTH stages with flush and occupancy count.
// Define PIPE_REG_SKID_EN to give each stage a skid register (capacity 2*DEPTH, registered in_ready).
module pipe_reg #(
    parameter int               WIDTH   = 6,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(2*DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(2*DEPTH+1);
    logic [DEPTH-1:0]            vld_q, vld_d, ofr;
    logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d, src;
    logic [DEPTH:0]              rdy;
    logic [CW-1:0]               count_q, count_d;
    logic                        in_fire, out_fire;
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];
    assign count     = count_q;
    assign out_fire  = out_valid && out_ready;
    assign count_d   = flush ? '0 : count_q + CW'(in_fire) - CW'(out_fire);
`ifdef PIPE_REG_SKID_EN
    logic [DEPTH-1:0]            sv_q, sv_d;
    logic [DEPTH-1:0][WIDTH-1:0] sd_q, sd_d;
    logic                        acc, mv;
    // rdy[i] is purely registered, so out_ready never reaches in_ready
    always_comb begin
        vld_d = '0;
        dat_d = dat_q;
        sv_d = '0;
        sd_d = sd_q;
        acc = 1'b0;
        mv = 1'b0;
        rdy = {out_ready, ~sv_q};
        in_ready = rdy[0] && !flush && !rst;
        in_fire = in_valid && in_ready;
        ofr = DEPTH'({vld_q, in_fire});
        src = (DEPTH*WIDTH)'({dat_q, in_data});
        for (int i = 0; i < DEPTH; i++) begin
            acc = !flush && ofr[i] && rdy[i];
            mv = !flush && (!vld_q[i] || rdy[i+1]);
            vld_d[i] = !flush && (mv ? (sv_q[i] || acc) : 1'b1);
            sv_d[i] = !flush && !mv && (sv_q[i] || acc);
            dat_d[i] = mv ? (sv_q[i] ? sd_q[i] : acc ? src[i] : dat_q[i]) : dat_q[i];
            sd_d[i] = (!mv && acc) ? src[i] : sd_q[i];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sv_q <= '0;
            sd_q <= {DEPTH{RST_VAL}};
        end else begin
            sv_q <= sv_d;
            sd_q <= sd_d;
        end
    end
`else
    // ready ripples back from out_ready so a full pipe can accept while draining
    always_comb begin
        vld_d = '0;
        dat_d = dat_q;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) rdy[i] = !vld_q[i] || rdy[i+1];
        in_ready = rdy[0] && !flush && !rst;
        in_fire = in_valid && in_ready;
        ofr = DEPTH'({vld_q, in_fire});
        src = (DEPTH*WIDTH)'({dat_q, in_data});
        for (int i = 0; i < DEPTH; i++) begin
            vld_d[i] = !flush && ((ofr[i] && rdy[i]) || (vld_q[i] && !rdy[i+1]));
            dat_d[i] = (!flush && ofr[i] && rdy[i]) ? src[i] : dat_q[i];
        end
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= {DEPTH{RST_VAL}};
            count_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed scenarios for pipe_reg (WIDTH=6, DEPTH=2) with a transfer scoreboard.
module tb_pipe_reg;
`ifdef PIPE_REG_SKID_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 2;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [5:0] in_data = '0;
    logic       in_ready, out_valid, in_ready2, out_valid2;
    logic [5:0] out_data, out_data2;
    logic [2:0] count, count2;
    logic [5:0] exp_q[$];
    int         n_chk = 0, n_err = 0;

    pipe_reg #(.WIDTH(6), .DEPTH(2), .RST_VAL(6'h00)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush), .count(count)
    );
    pipe_reg #(.WIDTH(6), .DEPTH(2), .RST_VAL(6'h2A)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .flush(flush), .count(count2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // samples handshakes before the edge, then scores the output transfer
    task automatic step;
        logic inf, outf, fl;
        logic [5:0] ind, od, e;
        #1;
        inf = in_valid && in_ready;
        ind = in_data;
        outf = out_valid && out_ready;
        od = out_data;
        fl = flush;
        @(posedge clk);
        #1;
        if (inf) exp_q.push_back(ind);
        if (outf) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_extra: out_data=%h required no output", od);
            end else begin
                e = exp_q.pop_front();
                if (od !== e) begin
                    n_err++;
                    $display("FAIL scoreboard: out_data=%h required %h", od, e);
                end
            end
        end
        if (fl) exp_q.delete();
    endtask

    task automatic drain(input string nm);
        int k = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while ((out_valid || count != 0) && k < 20) begin
            step;
            k++;
        end
        n_chk++;
        if (out_valid !== 1'b0 || count !== 3'd0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: out_valid=%b count=%0d pending=%0d required 0/0/0", nm, out_valid, count, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 3'd0 || out_data !== 6'h00) begin
            n_err++;
            $display("FAIL reset_hold: in_ready=%b out_valid=%b count=%0d out_data=%h required 0/0/0/00", in_ready, out_valid, count, out_data);
        end
        n_chk++;
        if (out_valid2 !== 1'b0 || out_data2 !== 6'h2A) begin
            n_err++;
            $display("FAIL reset_rstval: out_valid=%b out_data=%h required 0/2a", out_valid2, out_data2);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_stream;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 6'h01;
        step;
        n_chk++;
        if (out_valid !== 1'b0 || count !== 3'd1) begin
            n_err++;
            $display("FAIL stream_edge1: out_valid=%b count=%0d required 0/1", out_valid, count);
        end
        in_data = 6'h02;
        step;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 6'h01 || count !== 3'd2) begin
            n_err++;
            $display("FAIL stream_edge2: out_valid=%b out_data=%h count=%0d required 1/01/2", out_valid, out_data, count);
        end
        in_data = 6'h03;
        step;
        n_chk++;
        if (out_data !== 6'h02 || count !== 3'd2) begin
            n_err++;
            $display("FAIL stream_edge3: out_data=%h count=%0d required 02/2", out_data, count);
        end
        in_valid = 1'b0;
        step;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 6'h03 || count !== 3'd1) begin
            n_err++;
            $display("FAIL stream_edge4: out_valid=%b out_data=%h count=%0d required 1/03/1", out_valid, out_data, count);
        end
        drain("stream");
    endtask

    task automatic test_backpressure;
        int pushed = 0;
        logic acc;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < CAP + 3; k++) begin
            in_data = 6'h0A + 6'(pushed);
            #1;
            acc = in_ready;
            step;
            if (acc) pushed++;
            if (k >= 1) begin
                n_chk++;
                if (out_valid !== 1'b1 || out_data !== 6'h0A) begin
                    n_err++;
                    $display("FAIL bp_hold_%0d: out_valid=%b out_data=%h required 1/0a", k, out_valid, out_data);
                end
            end
        end
        n_chk++;
        if (pushed != CAP || in_ready !== 1'b0 || count !== 3'(CAP)) begin
            n_err++;
            $display("FAIL bp_full: accepted=%0d in_ready=%b count=%0d required %0d/0/%0d", pushed, in_ready, count, CAP, CAP);
        end
        drain("bp");
    endtask

    task automatic test_full_push;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < CAP; k++) begin
            in_data = 6'h13 + 6'(k);
            step;
        end
        out_ready = 1'b1;
        in_data = 6'h20;
        #1;
`ifdef PIPE_REG_SKID_EN
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready: in_ready=%b required 0", in_ready);
        end
        step;
        n_chk++;
        if (count !== 3'(CAP - 1) || out_data !== 6'h14) begin
            n_err++;
            $display("FAIL full_pop: count=%0d out_data=%h required %0d/14", count, out_data, CAP - 1);
        end
`else
        in_data = 6'h15;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_ready: in_ready=%b required 1", in_ready);
        end
        step;
        n_chk++;
        if (count !== 3'd2 || out_data !== 6'h14) begin
            n_err++;
            $display("FAIL full_pushpop: count=%0d out_data=%h required 2/14", count, out_data);
        end
`endif
        drain("full");
    endtask

    task automatic test_flush;
        in_valid = 1'b1;
        out_ready = 1'b0;
        in_data = 6'h21;
        step;
        in_data = 6'h22;
        step;
        flush = 1'b1;
        in_data = 6'h3F;
        #1;
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
        end
        step;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 6'h21) begin
            n_err++;
            $display("FAIL flush_clear: count=%0d out_valid=%b out_data=%h required 0/0/21", count, out_valid, out_data);
        end
        out_ready = 1'b1;
        repeat (3) step;
        n_chk++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL flush_nothing_out: out_valid=%b pending=%0d required 0/0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_async_reset;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < CAP; k++) begin
            in_data = 6'h30 + 6'(k);
            step;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_chk++;
        if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 6'h00 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst: out_valid=%b count=%0d out_data=%h in_ready=%b required 0/0/00/0", out_valid, count, out_data, in_ready);
        end
        n_chk++;
        if (out_valid2 !== 1'b0 || out_data2 !== 6'h2A || count2 !== 3'd0) begin
            n_err++;
            $display("FAIL async_rst_rstval: out_valid=%b out_data=%h count=%0d required 0/2a/0", out_valid2, out_data2, count2);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_data = 6'h05;
        step;
        in_valid = 1'b0;
        n_chk++;
        if (count !== 3'd1) begin
            n_err++;
            $display("FAIL async_first_xfer: count=%0d required 1", count);
        end
        step;
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== 6'h05) begin
            n_err++;
            $display("FAIL async_first_out: out_valid=%b out_data=%h required 1/05", out_valid, out_data);
        end
        drain("async");
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_full_push;
        test_flush;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
